// File: rtl/div_sqrt_arb_mvp.sv
// div_sqrt_arb_mvp
//   Shares one iterative div/sqrt unit between NUM_REQ FPU lanes. A round-robin
//   arbiter grants one request at a time. The FSM (IDLE -> ISSUE -> BUSY -> RESP)
//   drives the unit's start/kill/done handshake and routes the result back to
//   the lane that was granted.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   TIMEOUT  watchdog limit in BUSY cycles (only used with DIV_SQRT_ARB_TIMEOUT_EN)
//
// Configuration macro
//   DIV_SQRT_ARB_TIMEOUT_EN  when defined, adds an 8-bit BUSY watchdog. When the
//                            watchdog expires it kills the unit and answers with
//                            result 0, flags NV, and Rsp_timeout_SO=1.
//
// Ports
//   Clk_CI / Rst_RI                       clock, synchronous active-high reset
//   Req_valid_SI/Req_ready_SO             per-lane request handshake (ready one-hot)
//   Req_sqrt_SI/Req_fmt_DI                per-lane op select and format
//   Req_opa_DI/Req_opb_DI                 per-lane operands (64 bits per lane)
//   Kill_SI                               per-lane abort of its own request/response
//   Rsp_valid_SO/Rsp_ready_SI             per-lane response handshake (valid one-hot)
//   Rsp_result_DO/Rsp_flags_DO            result and IEEE flags {NV,DZ,OF,UF,NX}
//   Rsp_timeout_SO                        response was produced by the watchdog
//   Unit_div_start_SO/Unit_sqrt_start_SO  one-cycle start pulses to the unit
//   Unit_kill_SO                          one-cycle kill pulse to the unit
//   Unit_fmt_DO/Unit_opa_DO/Unit_opb_DO   latched operands, held from ISSUE through BUSY
//   Unit_ready_SI/Unit_done_SI            unit idle indication / one-cycle result valid
//   Unit_result_DI/Unit_flags_DI          unit result, valid together with Unit_done_SI
module div_sqrt_arb_mvp #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 127
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic [NUM_REQ-1:0]    Req_valid_SI,
  output logic [NUM_REQ-1:0]    Req_ready_SO,
  input  logic [NUM_REQ-1:0]    Req_sqrt_SI,
  input  logic [NUM_REQ*2-1:0]  Req_fmt_DI,
  input  logic [NUM_REQ*64-1:0] Req_opa_DI,
  input  logic [NUM_REQ*64-1:0] Req_opb_DI,
  input  logic [NUM_REQ-1:0]    Kill_SI,
  output logic [NUM_REQ-1:0]    Rsp_valid_SO,
  input  logic [NUM_REQ-1:0]    Rsp_ready_SI,
  output logic [63:0]           Rsp_result_DO,
  output logic [4:0]            Rsp_flags_DO,
  output logic                  Rsp_timeout_SO,
  output logic                  Unit_div_start_SO,
  output logic                  Unit_sqrt_start_SO,
  output logic                  Unit_kill_SO,
  output logic [1:0]            Unit_fmt_DO,
  output logic [63:0]           Unit_opa_DO,
  output logic [63:0]           Unit_opb_DO,
  input  logic                  Unit_ready_SI,
  input  logic                  Unit_done_SI,
  input  logic [63:0]           Unit_result_DI,
  input  logic [4:0]            Unit_flags_DI
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d;
  logic          sqrt_q, sqrt_d;
  logic [1:0]    fmt_q, fmt_d;
  logic [63:0]   opa_q, opa_d, opb_q, opb_d;
  logic [63:0]   result_q, result_d;
  logic [4:0]    flags_q, flags_d;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // Round-robin search: the first eligible lane at or after rr_q, wrapping
  // around. A lane that raises kill in the same cycle is not eligible.
  logic [NUM_REQ-1:0] elig;
  logic               gnt_found;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      idx;

  always_comb begin
    elig      = Req_valid_SI & ~Kill_SI;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(rr_q) + i) % NUM_REQ);
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  logic          owner_kill;
  logic [IW-1:0] nxt_ptr;
  assign owner_kill = Kill_SI[owner_q];
  assign nxt_ptr    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d            = state_q;
    rr_d               = rr_q;
    owner_d            = owner_q;
    sqrt_d             = sqrt_q;
    fmt_d              = fmt_q;
    opa_d              = opa_q;
    opb_d              = opb_q;
    result_d           = result_q;
    flags_d            = flags_q;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    cnt_d              = cnt_q;
    timeout_d          = timeout_q;
`endif
    Req_ready_SO       = '0;
    Rsp_valid_SO       = '0;
    Unit_div_start_SO  = 1'b0;
    Unit_sqrt_start_SO = 1'b0;
    Unit_kill_SO       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          Req_ready_SO[gnt_idx] = 1'b1;
          owner_d = gnt_idx;
          sqrt_d  = Req_sqrt_SI[gnt_idx];
          fmt_d   = Req_fmt_DI[int'(gnt_idx)*2 +: 2];
          opa_d   = Req_opa_DI[int'(gnt_idx)*64 +: 64];
          opb_d   = Req_opb_DI[int'(gnt_idx)*64 +: 64];
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A kill takes priority over the start, so the unit never sees both.
        if (owner_kill) begin
          Unit_kill_SO = 1'b1;
          rr_d         = nxt_ptr;
          state_d      = S_IDLE;
        end else if (Unit_ready_SI) begin
          Unit_div_start_SO  = ~sqrt_q;
          Unit_sqrt_start_SO = sqrt_q;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // A kill beats a done that arrives in the same cycle; the result is discarded.
        if (owner_kill) begin
          Unit_kill_SO = 1'b1;
          rr_d         = nxt_ptr;
          state_d      = S_IDLE;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        end else if (!Unit_done_SI && cnt_q == 8'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th BUSY cycle with no result.
          Unit_kill_SO = 1'b1;
          result_d     = '0;
          flags_d      = 5'b10000;
          timeout_d    = 1'b1;
          state_d      = S_RESP;
`endif
        end else if (Unit_done_SI) begin
          result_d = Unit_result_DI;
          flags_d  = Unit_flags_DI;
          state_d  = S_RESP;
        end else begin
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      S_RESP: begin
        if (owner_kill) begin
          rr_d    = nxt_ptr;
          state_d = S_IDLE;
        end else begin
          Rsp_valid_SO[owner_q] = 1'b1;
          if (Rsp_ready_SI[owner_q]) begin
            rr_d    = nxt_ptr;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      sqrt_q    <= 1'b0;
      fmt_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      sqrt_q    <= sqrt_d;
      fmt_q     <= fmt_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign Rsp_result_DO = result_q;
  assign Rsp_flags_DO  = flags_q;
  assign Unit_fmt_DO   = fmt_q;
  assign Unit_opa_DO   = opa_q;
  assign Unit_opb_DO   = opb_q;

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  assign Rsp_timeout_SO = timeout_q && (state_q == S_RESP);
`else
  assign Rsp_timeout_SO = 1'b0;
`endif

endmodule
